// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: frame codes, field sizes, FSM encoding and ID register indices.
// Used by both the target and the controller side of the management bus.
package mdio_pkg;

  localparam int REG_AW    = 5;
  localparam int REG_DW    = 16;
  localparam int REG_COUNT = 32;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // Last value of the shared bit counter in each counted phase.
  localparam logic [3:0] HDR_LAST  = 4'd11;
  localparam logic [3:0] TA_LAST   = 4'd1;
  localparam logic [3:0] DATA_LAST = 4'd15;

  localparam logic [REG_AW-1:0] REG_ID_HI = 5'd2;
  localparam logic [REG_AW-1:0] REG_ID_LO = 5'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_HDR,
    S_TA,
    S_DATA
  } state_e;

  function automatic logic is_id_reg(input logic [REG_AW-1:0] addr);
    return (addr == REG_ID_HI) || (addr == REG_ID_LO);
  endfunction

endpackage

// File: rtl/mdio_target_regfile.sv
// 32 x 16 management register file with read-only PHY identifier registers.
// Asynchronous read port; the write port silently ignores the ID registers.
module mdio_target_regfile
  import mdio_pkg::*;
#(
  parameter logic [15:0] PHY_ID_HI = 16'h0022,
  parameter logic [15:0] PHY_ID_LO = 16'h1560
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [REG_DW-1:0] wr_data,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [REG_DW-1:0] rd_data
);

  logic [REG_DW-1:0] mem [REG_COUNT];

  // NOTE: this storage is reset because software expects zeroed registers after
  // reset; a plain RAM without reset would map to denser memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
    end else if (wr_en && !is_id_reg(wr_addr)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = mem[rd_addr];
    if (rd_addr == REG_ID_HI) rd_data = PHY_ID_HI;
    if (rd_addr == REG_ID_LO) rd_data = PHY_ID_LO;
  end

endmodule

// File: rtl/mdio_target.sv
// MDIO management target: decodes clause-22 style frames sampled on MDC rising
// edges (oversampled by clk), serves reads from the register file and commits writes.
module mdio_target
  import mdio_pkg::*;
#(
  parameter logic [15:0] PHY_ID_HI = 16'h0022,
  parameter logic [15:0] PHY_ID_LO = 16'h1560
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_in,
  input  logic [4:0]  phy_addr,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic        reg_wr,
  output logic [4:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        busy
);

  state_e state, state_nx;

  logic        mdc_q;
  logic        mdc_rise;
  logic [3:0]  cnt, cnt_nx;
  logic [10:0] hdr_sr, hdr_sr_nx;
  logic [11:0] hdr_full;
  logic [15:0] sr, sr_nx;
  logic        frame_rd, frame_rd_nx;
  logic        frame_wr, frame_wr_nx;
  logic [4:0]  regad, regad_nx;
  logic        addressed;
  logic        oe_nx, out_nx, wr_nx;
  logic [4:0]  wr_addr_nx;
  logic [15:0] wr_data_nx;
  logic [15:0] rf_rdata;

  assign mdc_rise  = mdc & ~mdc_q;
  assign hdr_full  = {hdr_sr, mdio_in};
  assign addressed = (hdr_full[9:5] == phy_addr) &&
                     ((hdr_full[11:10] == OP_READ) || (hdr_full[11:10] == OP_WRITE));
  assign busy      = (state != S_IDLE);

  // NOTE: every register here uses <= so all flops update together from
  // pre-edge values; blocking assignments would create order-dependent logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      mdc_q       <= 1'b0;
      cnt         <= '0;
      hdr_sr      <= '0;
      sr          <= '0;
      frame_rd    <= 1'b0;
      frame_wr    <= 1'b0;
      regad       <= '0;
      mdio_oe     <= 1'b0;
      mdio_out    <= 1'b0;
      reg_wr      <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
    end else begin
      state       <= state_nx;
      mdc_q       <= mdc;
      cnt         <= cnt_nx;
      hdr_sr      <= hdr_sr_nx;
      sr          <= sr_nx;
      frame_rd    <= frame_rd_nx;
      frame_wr    <= frame_wr_nx;
      regad       <= regad_nx;
      mdio_oe     <= oe_nx;
      mdio_out    <= out_nx;
      reg_wr      <= wr_nx;
      reg_wr_addr <= wr_addr_nx;
      reg_wr_data <= wr_data_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (mdc_rise) begin
      case (state)
        S_IDLE:  if (mdio_in == ST_CODE[1]) state_nx = S_START;
        S_START: if (mdio_in == ST_CODE[0]) state_nx = S_HDR;
        S_HDR:   if (cnt == HDR_LAST)       state_nx = S_TA;
        S_TA:    if (cnt == TA_LAST)        state_nx = S_DATA;
        S_DATA:  if (cnt == DATA_LAST)      state_nx = S_IDLE;
        default:                            state_nx = S_IDLE;
      endcase
    end
  end

  // NOTE: each variable gets a hold value first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    cnt_nx      = cnt;
    hdr_sr_nx   = hdr_sr;
    sr_nx       = sr;
    frame_rd_nx = frame_rd;
    frame_wr_nx = frame_wr;
    regad_nx    = regad;
    oe_nx       = mdio_oe;
    out_nx      = mdio_out;
    wr_nx       = 1'b0;
    wr_addr_nx  = reg_wr_addr;
    wr_data_nx  = reg_wr_data;
    if (mdc_rise) begin
      case (state)
        S_IDLE: begin
          // The first edge after a read frame releases the line.
          oe_nx  = 1'b0;
          out_nx = 1'b0;
          cnt_nx = '0;
        end
        S_START: cnt_nx = '0;
        S_HDR: begin
          hdr_sr_nx = hdr_full[10:0];
          cnt_nx    = cnt + 4'd1;
          if (cnt == HDR_LAST) begin
            cnt_nx      = '0;
            frame_rd_nx = addressed && (hdr_full[11:10] == OP_READ);
            frame_wr_nx = addressed && (hdr_full[11:10] == OP_WRITE);
            regad_nx    = hdr_full[4:0];
            sr_nx       = rf_rdata;
          end
        end
        S_TA: begin
          cnt_nx = cnt + 4'd1;
          if (cnt == TA_LAST) begin
            cnt_nx = '0;
            if (frame_rd) begin
              oe_nx  = 1'b1;
              out_nx = 1'b0;
            end
          end
        end
        S_DATA: begin
          cnt_nx = cnt + 4'd1;
          if (frame_rd) begin
            out_nx = sr[15];
            sr_nx  = {sr[14:0], 1'b0};
          end else begin
            sr_nx  = {sr[14:0], mdio_in};
          end
          if (cnt == DATA_LAST) begin
            cnt_nx = '0;
            if (frame_wr && !is_id_reg(regad)) begin
              wr_nx      = 1'b1;
              wr_addr_nx = regad;
              wr_data_nx = {sr[14:0], mdio_in};
            end
          end
        end
        default: cnt_nx = '0;
      endcase
    end
  end

  // Storage is written from the next-state values so it updates with the reg_wr pulse.
  mdio_target_regfile #(
    .PHY_ID_HI (PHY_ID_HI),
    .PHY_ID_LO (PHY_ID_LO)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_nx),
    .wr_addr (wr_addr_nx),
    .wr_data (wr_data_nx),
    .rd_addr (hdr_full[4:0]),
    .rd_data (rf_rdata)
  );

endmodule

// File: tb/tb_mdio_target.sv
// Scoreboard bench for mdio_target: frames are driven bit by bit, expected
// read words and write commits are queued at drive time and matched by a monitor.
module tb_mdio_target;

  localparam logic [4:0]  PHY   = 5'h03;
  localparam logic [15:0] ID_HI = 16'h0022;
  localparam logic [15:0] ID_LO = 16'h1560;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdc;
  logic        mdio_in;
  logic [4:0]  phy_addr;
  logic        mdio_out;
  logic        mdio_oe;
  logic        reg_wr;
  logic [4:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic        busy;

  always #5 clk = ~clk;

  mdio_target dut (
    .clk         (clk),
    .reset       (reset),
    .mdc         (mdc),
    .mdio_in     (mdio_in),
    .phy_addr    (phy_addr),
    .mdio_out    (mdio_out),
    .mdio_oe     (mdio_oe),
    .reg_wr      (reg_wr),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .busy        (busy)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] model_mem [32];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [4:0] a);
    if (a == 5'd2) return ID_HI;
    if (a == 5'd3) return ID_LO;
    return model_mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_mem[i] = '0;
  endtask

  // Monitor: the controller samples the line on each MDC rise while the target drives.
  logic        mdc_seen = 1'b0;
  logic        wr_prev  = 1'b0;
  int          rd_nbits = 0;
  int          oe_cycles = 0;
  logic [16:0] rd_shift = '0;

  always @(negedge clk) begin
    if (reset) begin
      rd_nbits = 0;
      wr_prev  = 1'b0;
    end else begin
      if (mdio_oe) oe_cycles++;
      if (!mdio_oe) begin
        rd_nbits = 0;
      end else if (mdc && !mdc_seen) begin
        rd_shift = {rd_shift[15:0], mdio_out};
        rd_nbits++;
        if (rd_nbits == 17) begin
          rd_nbits = 0;
          check("ta2_drive", 32'(rd_shift[16]), 32'd0);
          if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
          else check("rd_data", 32'(rd_shift[15:0]), 32'(rd_q.pop_front()));
        end
      end
      if (reg_wr) begin
        wr_t e;
        check("wr_width", 32'(wr_prev), 32'd0);
        if (exp_wr_q.size() == 0) begin
          check("wr_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_addr", 32'(reg_wr_addr), 32'(e.addr));
          check("wr_data", 32'(reg_wr_data), 32'(e.data));
        end
      end
      wr_prev = reg_wr;
    end
    mdc_seen = mdc;
  end

  task automatic mdc_bit(input logic b, input int half);
    mdio_in = b;
    mdc     = 1'b0;
    repeat (half) @(posedge clk);
    #1;
    mdc = 1'b1;
    repeat (half) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input int half);
    for (int i = 0; i < n; i++) mdc_bit(1'b1, half);
  endtask

  task automatic send_frame(input logic [1:0] op, input logic [4:0] phyad, input logic [4:0] regad,
                            input logic [15:0] data, input int half, input int stop_after);
    logic [31:0] fr;
    logic        addressed;
    logic        is_rd;
    addressed = (phyad == PHY) && (op == 2'b01 || op == 2'b10);
    is_rd     = addressed && (op == 2'b10);
    fr = {2'b01, op, phyad, regad, 2'b10, is_rd ? 16'($urandom) : data};
    if (is_rd) begin
      rd_q.push_back(model_read(regad));
    end else if (addressed && regad != 5'd2 && regad != 5'd3) begin
      exp_wr_q.push_back('{regad, data});
      model_mem[regad] = data;
    end
    for (int i = 0; i < stop_after; i++) begin
      if (i == 31) check("busy_mid", 32'(busy), 32'd1);
      mdc_bit(fr[31-i], half);
      if (i == 14) check("ta1_oe", 32'(mdio_oe), 32'd0);
      if (i == 15) begin
        check("ta2_oe", 32'(mdio_oe), 32'(is_rd));
        if (is_rd) check("ta2_out", 32'(mdio_out), 32'd0);
      end
    end
    if (stop_after == 32) check("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int          oe_base;
    logic [15:0] dropped;
    mdc      = 1'b0;
    mdio_in  = 1'b1;
    phy_addr = PHY;
    reset    = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_oe",      32'(mdio_oe),     32'd0);
    check("rst_out",     32'(mdio_out),    32'd0);
    check("rst_wr",      32'(reg_wr),      32'd0);
    check("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
    check("rst_wr_data", 32'(reg_wr_data), 32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    reset = 1'b0;
    idle(2, 2);

    // Write then read back, with the line staying released during the write.
    oe_base = oe_cycles;
    send_frame(2'b01, PHY, 5'h04, 16'hA5C3, 2, 32);
    idle(2, 2);
    check("wr_oe_quiet", 32'(oe_cycles - oe_base), 32'd0);
    check("wr_done", 32'(exp_wr_q.size()), 32'd0);
    send_frame(2'b10, PHY, 5'h04, 16'h0000, 2, 32);
    idle(2, 2);
    check("rd_done", 32'(rd_q.size()), 32'd0);

    // ID registers: readable, writes discarded without a pulse.
    send_frame(2'b10, PHY, 5'h02, 16'h0000, 2, 32);
    send_frame(2'b01, PHY, 5'h03, 16'hFFFF, 2, 32);
    send_frame(2'b10, PHY, 5'h03, 16'h0000, 2, 32);
    idle(2, 2);

    // Foreign address, then an invalid opcode: frames counted but inert.
    oe_base = oe_cycles;
    send_frame(2'b01, 5'h07, 5'h04, 16'h5555, 2, 32);
    send_frame(2'b10, 5'h07, 5'h04, 16'h0000, 2, 32);
    send_frame(2'b11, PHY,   5'h04, 16'h0F0F, 2, 32);
    idle(2, 2);
    check("ign_oe_quiet", 32'(oe_cycles - oe_base), 32'd0);
    send_frame(2'b10, PHY, 5'h04, 16'h0000, 2, 32);

    // Long run of leading 1s before a frame.
    idle(32, 2);
    send_frame(2'b01, PHY, 5'h1F, 16'h1234, 2, 32);
    send_frame(2'b10, PHY, 5'h1F, 16'h0000, 2, 32);
    idle(2, 2);

    // Reset in the middle of a read, at data bit 8.
    send_frame(2'b10, PHY, 5'h04, 16'h0000, 2, 24);
    dropped = rd_q.pop_back();
    mdc   = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_oe",   32'(mdio_oe), 32'd0);
    check("rst_mid_busy", 32'(busy),    32'd0);
    reset = 1'b0;
    model_clear();
    idle(2, 2);
    send_frame(2'b10, PHY, 5'h04, 16'h0000, 2, 32);
    send_frame(2'b10, PHY, 5'h02, 16'h0000, 2, 32);
    idle(2, 2);

    // Back-to-back at mdc = clk/2 with no idle bits between frames.
    send_frame(2'b01, PHY, 5'h09, 16'hBEEF, 1, 32);
    send_frame(2'b10, PHY, 5'h09, 16'h0000, 1, 32);
    idle(2, 1);

    repeat (4) @(posedge clk);
    #1;
    check("sb_rd_empty", 32'(rd_q.size()),     32'd0);
    check("sb_wr_empty", 32'(exp_wr_q.size()), 32'd0);
    check("end_busy",    32'(busy),            32'd0);
    check("end_oe",      32'(mdio_oe),         32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
